// File: rtl/key_search.sv
`default_nettype none
// ============================================================================
// Module   : key_search
// Brief    : Brute-force key search driving an arc4 decryptor and checking the
//            decrypted plaintext (length-prefixed) for printable bytes.
// Revision : 1.0 - initial release
// ============================================================================
module key_search #(
    parameter logic [23:0] KEY_FIRST = 24'h000000,
    parameter logic [23:0] KEY_LAST  = 24'hFFFFFF,
    parameter logic [23:0] KEY_STEP  = 24'h000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    output logic [23:0] key,
    output logic        key_valid,
    output logic        arc4_en,
    input  logic        arc4_rdy,
    output logic [23:0] arc4_key,
    output logic        chk_active,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_WAIT_BUSY = 3'd2;
    localparam logic [2:0] c_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_RD_LEN    = 3'd4;
    localparam logic [2:0] c_CHECK     = 3'd5;
    localparam logic [2:0] c_NEXT_KEY  = 3'd6;

    localparam logic [7:0] c_PRINT_LO  = 8'h20;
    localparam logic [7:0] c_PRINT_HI  = 8'h7E;

    logic [2:0]  r_state,     w_state_nxt;
    logic [23:0] r_key,       w_key_nxt;
    logic        r_key_valid, w_key_valid_nxt;
    logic [7:0]  r_len,       w_len_nxt;
    logic [7:0]  r_idx,       w_idx_nxt;
    logic        r_len_phase, w_len_phase_nxt;
    logic        w_byte_ok;

    assign w_byte_ok = (pt_rddata >= c_PRINT_LO) && (pt_rddata <= c_PRINT_HI);
    assign key       = r_key;
    assign arc4_key  = r_key;
    assign key_valid = r_key_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_key       <= KEY_FIRST;
            r_key_valid <= 1'b0;
            r_len       <= 8'd0;
            r_idx       <= 8'd0;
            r_len_phase <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_key       <= w_key_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_len       <= w_len_nxt;
            r_idx       <= w_idx_nxt;
            r_len_phase <= w_len_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_key_nxt       = r_key;
        w_key_valid_nxt = r_key_valid;
        w_len_nxt       = r_len;
        w_idx_nxt       = r_idx;
        w_len_phase_nxt = r_len_phase;
        rdy             = 1'b0;
        arc4_en         = 1'b0;
        chk_active      = 1'b0;
        pt_addr         = 8'd0;

        case (r_state)
            c_IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    w_key_nxt       = KEY_FIRST;
                    w_key_valid_nxt = 1'b0;
                    w_state_nxt     = c_START;
                end
            end
            c_START: begin
                if (arc4_rdy) begin
                    arc4_en     = 1'b1;
                    w_state_nxt = c_WAIT_BUSY;
                end
            end
            c_WAIT_BUSY: begin
                if (!arc4_rdy) w_state_nxt = c_WAIT_DONE;
            end
            c_WAIT_DONE: begin
                if (arc4_rdy) w_state_nxt = c_RD_LEN;
            end
            c_RD_LEN: begin
                chk_active      = 1'b1;
                w_len_phase_nxt = 1'b1;
                w_idx_nxt       = 8'd0;
                w_state_nxt     = c_CHECK;
            end
            c_CHECK: begin
                chk_active = 1'b1;
                // r_idx is the address presented last cycle, i.e. the byte on pt_rddata now
                if (r_len_phase) begin
                    w_len_nxt       = pt_rddata;
                    w_len_phase_nxt = 1'b0;
                    if (pt_rddata == 8'd0) begin
                        w_key_valid_nxt = 1'b1;
                        w_state_nxt     = c_IDLE;
                    end else begin
                        pt_addr   = 8'd1;
                        w_idx_nxt = 8'd1;
                    end
                end else if (!w_byte_ok) begin
                    w_state_nxt = c_NEXT_KEY;
                end else if (r_idx == r_len) begin
                    w_key_valid_nxt = 1'b1;
                    w_state_nxt     = c_IDLE;
                end else begin
                    pt_addr   = r_idx + 8'd1;
                    w_idx_nxt = r_idx + 8'd1;
                end
            end
            c_NEXT_KEY: begin
                // Compare before incrementing so a wrapping step still terminates
                if (r_key == KEY_LAST) begin
                    w_key_valid_nxt = 1'b0;
                    w_state_nxt     = c_IDLE;
                end else begin
                    w_key_nxt   = r_key + KEY_STEP;
                    w_state_nxt = c_START;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_key_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_search
// Brief    : Self-checking bench for key_search with an arc4 responder and a
//            registered plaintext memory; dut0 searches keys 0..3, dut1 the top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_search;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       en = 2'b00;
    logic [1:0]       rdy, kv, a_en, chk;
    logic [1:0]       a_rdy = 2'b11;
    logic [1:0][23:0] key, a_key;
    logic [1:0][7:0]  pa;
    logic [1:0][7:0]  rd = '0;

    logic [7:0] mem [4][256];

    int         n_pulse [2] = '{0, 0};
    int         n_bad   [2] = '{0, 0};
    int         n_rd    [2] = '{0, 0};
    int         n_viol  [2] = '{0, 0};
    logic [1:0] ph      [2] = '{2'd0, 2'd0};
    int         cnt     [2] = '{0, 0};
    logic [7:0] last    [2] = '{8'd0, 8'd0};

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  b;
        logic        kv;
        logic [23:0] key;
        int          pulses;
        int          reads;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    key_search #(.KEY_FIRST(24'h000000), .KEY_LAST(24'h000003), .KEY_STEP(24'h000001)) dut0 (
        .clk(clk), .rst(rst), .en(en[0]), .rdy(rdy[0]), .key(key[0]), .key_valid(kv[0]),
        .arc4_en(a_en[0]), .arc4_rdy(a_rdy[0]), .arc4_key(a_key[0]),
        .chk_active(chk[0]), .pt_addr(pa[0]), .pt_rddata(rd[0])
    );

    key_search #(.KEY_FIRST(24'hFFFFFE), .KEY_LAST(24'hFFFFFF), .KEY_STEP(24'h000001)) dut1 (
        .clk(clk), .rst(rst), .en(en[1]), .rdy(rdy[1]), .key(key[1]), .key_valid(kv[1]),
        .arc4_en(a_en[1]), .arc4_rdy(a_rdy[1]), .arc4_key(a_key[1]),
        .chk_active(chk[1]), .pt_addr(pa[1]), .pt_rddata(rd[1])
    );

    // arc4 responders, plaintext memories and protocol monitors
    always @(posedge clk) begin
        int v;
        rd[0] <= mem[a_key[0][1:0]][pa[0]];
        rd[1] <= (pa[1] == 8'd0) ? 8'd1 : 8'h01;
        for (int g = 0; g < 2; g++) begin
            v = 0;
            if (chk[g] && pa[g] != 8'd0) begin
                n_rd[g] <= n_rd[g] + 1;
                if (pa[g] != last[g] + 8'd1) v++;
                last[g] <= pa[g];
            end else begin
                last[g] <= 8'd0;
            end
            if (!chk[g] && pa[g] != 8'd0) v++;
            if (a_key[g] !== key[g]) v++;
            if (a_en[g] && chk[g]) v++;
            n_viol[g] <= n_viol[g] + v;
            if (a_en[g]) n_pulse[g] <= n_pulse[g] + 1;
            case (ph[g])
                2'd0: begin
                    if (a_en[g]) begin
                        ph[g]  <= 2'd1;
                        cnt[g] <= int'($urandom_range(0, 2));
                    end
                end
                2'd1: begin
                    if (a_en[g]) n_bad[g] <= n_bad[g] + 1;
                    if (cnt[g] == 0) begin
                        a_rdy[g] <= 1'b0;
                        ph[g]    <= 2'd2;
                        cnt[g]   <= int'($urandom_range(1, 4));
                    end else begin
                        cnt[g] <= cnt[g] - 1;
                    end
                end
                default: begin
                    if (a_en[g]) n_bad[g] <= n_bad[g] + 1;
                    if (cnt[g] == 0) begin
                        a_rdy[g] <= 1'b1;
                        ph[g]    <= 2'd0;
                    end else begin
                        cnt[g] <= cnt[g] - 1;
                    end
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_all();
        for (int k = 0; k < 4; k++) begin
            mem[k][0] = 8'd1;
            mem[k][1] = 8'h01;
        end
    endtask

    task automatic pulse_en(input int g);
        @(negedge clk);
        en[g] = 1'b1;
        @(negedge clk);
        en[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int budget, output bit ok);
        int c;
        c = 0;
        while (!rdy[g] && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = rdy[g];
    endtask

    task automatic finish0(input string name, input int p0, input int r0, input logic ekv,
                           input logic [23:0] ekey, input int ep, input int er);
        bit ok;
        wait_idle(0, 4000, ok);
        check({name, " done"}, ok, 1);
        check({name, " key_valid"}, kv[0], ekv);
        check({name, " key"}, key[0], ekey);
        check({name, " arc4 pulses"}, n_pulse[0] - p0, ep);
        check({name, " byte reads"}, n_rd[0] - r0, er);
    endtask

    task automatic run0(input string name, input logic ekv, input logic [23:0] ekey,
                        input int ep, input int er);
        int p0, r0;
        p0 = n_pulse[0];
        r0 = n_rd[0];
        pulse_en(0);
        finish0(name, p0, r0, ekv, ekey, ep, er);
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 5))
            0:       return 8'h20;
            1:       return 8'h7E;
            2:       return 8'h1F;
            3:       return 8'h7F;
            4:       return 8'($urandom_range(32, 126));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          p0, r0, c, len, f, exp_p, exp_r;
        logic        exp_kv;
        logic [23:0] exp_key;
        bit          ok;

        tbl[0] = '{8'h20, 1'b1, 24'd0, 1, 3};
        tbl[1] = '{8'h7E, 1'b1, 24'd0, 1, 3};
        tbl[2] = '{8'h1F, 1'b0, 24'd3, 4, 5};
        tbl[3] = '{8'h7F, 1'b0, 24'd3, 4, 5};
        tbl[4] = '{8'h41, 1'b1, 24'd0, 1, 3};
        tbl[5] = '{8'h00, 1'b0, 24'd3, 4, 5};
        tbl[6] = '{8'hFF, 1'b0, 24'd3, 4, 5};
        tbl[7] = '{8'h80, 1'b0, 24'd3, 4, 5};

        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 256; a++) mem[k][a] = 8'h01;

        repeat (2) @(negedge clk);
        check("reset rdy", rdy[0], 1);
        check("reset key", key[0], 24'h000000);
        check("reset key_valid", kv[0], 0);
        check("reset arc4_en", a_en[0], 0);
        check("reset chk_active", chk[0], 0);
        check("reset pt_addr", pa[0], 0);
        check("reset dut1 key", key[1], 24'hFFFFFE);

        // Empty plaintext for key 0, with en on the first edge after reset release
        fail_all();
        mem[0][0] = 8'd0;
        p0 = n_pulse[0];
        r0 = n_rd[0];
        rst   = 1'b0;
        en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        check("first en accepted", rdy[0], 0);
        finish0("len0", p0, r0, 1'b1, 24'd0, 1, 0);

        // Key 2 decrypts to "abc"; extra en while busy must be dropped
        fail_all();
        mem[2][0] = 8'd3;
        mem[2][1] = 8'h61;
        mem[2][2] = 8'h62;
        mem[2][3] = 8'h63;
        p0 = n_pulse[0];
        r0 = n_rd[0];
        pulse_en(0);
        repeat (2) @(negedge clk);
        en[0] = 1'b1;
        repeat (3) @(negedge clk);
        en[0] = 1'b0;
        finish0("abc", p0, r0, 1'b1, 24'd2, 3, 5);
        p0 = n_pulse[0];
        c  = 0;
        repeat (8) begin
            @(negedge clk);
            if (!rdy[0]) c++;
        end
        check("busy en ignored rdy", c, 0);
        check("busy en ignored pulses", n_pulse[0] - p0, 0);

        for (int v = 0; v < 8; v++) begin
            fail_all();
            mem[0][0] = 8'd3;
            mem[0][1] = 8'h41;
            mem[0][2] = tbl[v].b;
            mem[0][3] = 8'h41;
            run0($sformatf("tbl%0d byte %02h", v, tbl[v].b), tbl[v].kv, tbl[v].key,
                 tbl[v].pulses, tbl[v].reads);
        end

        fail_all();
        mem[0][0] = 8'd255;
        for (int i = 1; i < 256; i++) mem[0][i] = 8'(8'h20 + (i % 95));
        run0("len255", 1'b1, 24'd0, 1, 255);

        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < 4; k++) begin
                len = int'($urandom_range(0, 5));
                mem[k][0] = 8'(len);
                for (int i = 1; i <= len; i++) mem[k][i] = pick_byte();
            end
            exp_kv  = 1'b0;
            exp_key = 24'd3;
            exp_p   = 4;
            exp_r   = 0;
            for (int k = 0; k < 4; k++) begin
                len = int'(mem[k][0]);
                f   = 0;
                for (int i = 1; i <= len; i++) begin
                    if (mem[k][i] < 8'h20 || mem[k][i] > 8'h7E) begin
                        f = i;
                        break;
                    end
                end
                if (f == 0) begin
                    exp_r   += len;
                    exp_kv  = 1'b1;
                    exp_key = 24'(k);
                    exp_p   = k + 1;
                    break;
                end
                exp_r += f;
            end
            run0($sformatf("rand%0d", t), exp_kv, exp_key, exp_p, exp_r);
        end

        // Top-of-range search must stop at KEY_LAST rather than wrapping to 0
        p0 = n_pulse[1];
        r0 = n_rd[1];
        pulse_en(1);
        wait_idle(1, 2000, ok);
        check("wrap done", ok, 1);
        check("wrap key_valid", kv[1], 0);
        check("wrap key", key[1], 24'hFFFFFF);
        check("wrap arc4 pulses", n_pulse[1] - p0, 2);
        check("wrap byte reads", n_rd[1] - r0, 2);

        // Reset while the second key waits for arc4 to finish
        fail_all();
        p0 = n_pulse[0];
        pulse_en(0);
        c = 0;
        while (n_pulse[0] - p0 < 2 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        c = 0;
        while (a_rdy[0] && c < 50) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        check("pre-reset key", key[0], 24'd1);
        check("pre-reset arc4 busy", a_rdy[0], 0);
        #1 rst = 1'b1;
        #1;
        check("midrst rdy", rdy[0], 1);
        check("midrst key", key[0], 24'd0);
        check("midrst key_valid", kv[0], 0);
        check("midrst chk_active", chk[0], 0);
        check("midrst arc4_en", a_en[0], 0);
        @(negedge clk);
        rst = 1'b0;
        p0  = n_pulse[0];
        c   = 0;
        repeat (12) begin
            @(negedge clk);
            if (!rdy[0]) c++;
        end
        check("post-reset idle", c, 0);
        check("post-reset no pulses", n_pulse[0] - p0, 0);
        mem[1][0] = 8'd1;
        mem[1][1] = 8'h41;
        run0("restart", 1'b1, 24'd1, 2, 2);

        check("dut0 arc4 protocol", n_bad[0], 0);
        check("dut1 arc4 protocol", n_bad[1], 0);
        check("dut0 read port", n_viol[0], 0);
        check("dut1 read port", n_viol[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_search.md
KEY_SEARCH -- requirements
Module: key_search

Interface
REQ-001 SHALL have parameter KEY_FIRST, default 24'h000000, first key tried.
REQ-002 SHALL have parameter KEY_LAST, default 24'hFFFFFF, last key tried; search ends after it fails.
REQ-003 SHALL have parameter KEY_STEP, default 24'h000001, increment between keys (modulo 2^24).
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on posedge clk.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port en  in  1  start request; accepted only in a cycle where rdy=1.
REQ-007 SHALL have port rdy  out  1  high only in IDLE.
REQ-008 SHALL have port key  out  24  last key tested; holds the found key when key_valid=1.
REQ-009 SHALL have port key_valid  out  1  high after a search that found a key; held until the next accepted en.
REQ-010 SHALL have port arc4_en  out  1  start pulse to the downstream arc4 decryptor.
REQ-011 SHALL have port arc4_rdy  in  1  arc4 idle indication (high = idle).
REQ-012 SHALL have port arc4_key  out  24  key driven to arc4; equals key at all times.
REQ-013 SHALL have port chk_active  out  1  high while this block owns the plaintext-memory read port (RD_LEN, CHECK).
REQ-014 SHALL have port pt_addr  out  8  plaintext-memory read address.
REQ-015 SHALL have port pt_rddata  in  8  plaintext-memory read data, valid one cycle after pt_addr is presented.

Function
REQ-016 SHALL implement states IDLE, START, WAIT_BUSY, WAIT_DONE, RD_LEN, CHECK, NEXT_KEY.
REQ-017 IDLE: en=1 -> key<=KEY_FIRST, key_valid<=0, go START; otherwise key/key_valid hold.
REQ-018 START: arc4_en=1 only in a cycle where arc4_rdy=1, then go WAIT_BUSY; if arc4_rdy=0, stay in START with arc4_en=0.
REQ-019 arc4_en SHALL be a single-cycle pulse per key; it SHALL be 0 in every other state.
REQ-020 WAIT_BUSY: wait for arc4_rdy=0, then go WAIT_DONE; WAIT_DONE: wait for arc4_rdy=1, then go RD_LEN.
REQ-021 RD_LEN: pt_addr=0; the next cycle latches length L=pt_rddata; L=0 -> pass.
REQ-022 CHECK: reads addresses 1..L in order, one per cycle, pipelined so that byte i is checked one cycle after its address is presented.
REQ-023 A byte SHALL pass iff 8'h20 <= byte <= 8'h7E (inclusive); the first failing byte aborts the check immediately (no further reads) and goes to NEXT_KEY.
REQ-024 All L bytes passing -> key_valid<=1, go IDLE with key unchanged.
REQ-025 NEXT_KEY: if key==KEY_LAST -> key_valid<=0, go IDLE; else key<=key+KEY_STEP (24-bit wrap), go START.
REQ-026 The KEY_LAST comparison SHALL precede the increment, so the search terminates even when key+KEY_STEP wraps past 24'hFFFFFF.
REQ-027 pt_addr SHALL be 8 bits; L=255 reads addresses 1..255 without wrapping to 0.
REQ-028 Latency per rejected key, excluding arc4 time: bounded by 4 + (index of the failing byte) cycles.
REQ-029 en asserted while rdy=0 SHALL be ignored and SHALL NOT queue.
REQ-030 chk_active=1 exactly in RD_LEN and CHECK; pt_addr=0 when chk_active=0.

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE, rdy=1, key=KEY_FIRST, key_valid=0, arc4_en=0, chk_active=0, pt_addr=0, L=0.
REQ-032 rst asserted mid-search (any state) SHALL abandon the search with no further arc4_en pulse; operation resumes only after a new en.
REQ-033 After rst deasserts, the first en SHALL be accepted on the first clk edge.

Verification
REQ-034 Plaintext model returns L=3, bytes "abc" for key 24'h000002 and byte 8'h01 at address 1 for all other keys; pulse en -> three arc4_en pulses, key_valid=1, key=24'h000002, rdy=1.
REQ-035 KEY_FIRST=0, KEY_LAST=3, all keys fail -> exactly four arc4_en pulses, key_valid=0, key=3, return to IDLE.
REQ-036 L=0 for key 0 -> key_valid=1, key=0 after one arc4 run; pt_addr never exceeds 0.
REQ-037 Boundary bytes: 8'h20 and 8'h7E pass; 8'h1F and 8'h7F at index 2 fail, and no read of index 3 occurs.
REQ-038 KEY_FIRST=24'hFFFFFE, KEY_LAST=24'hFFFFFF, KEY_STEP=1, all keys fail -> two runs, then IDLE, no wrap to key 0.
REQ-039 rst pulsed during WAIT_DONE -> outputs immediately take reset values; a subsequent en restarts at KEY_FIRST.
